memory_sequencer: RTL and testbench
===================================

// Module: memory_sequencer
// PURPOSE
//   Bus sequencer between the CPU memory port and the word-addressed RAM model.
//   Turns a CPU req/ack handshake into a timed RAM access with programmable wait states.
//   Rejects out-of-range addresses and raises sticky sim_end on the halt write.
//   Sits directly upstream of the RAM; the test bench wires CPU -> memory_sequencer -> RAM.
// PARAMETERS
//   WAIT_STATES   2          cycles spent in WAIT per access (0 = skip WAIT)
//   ADDRESS_MASK  17'h1ff    implemented word-address bits; any bit outside = out of range
//   HALT_ADDRESS  17'h00100  word address of the simulation-stop write
//   HALT_DATA     32'h00010001  data value that triggers sim_end
// PORTS
//   clock         in   1      rising-edge clock
//   reset         in   1      asynchronous, active-low
//   cpu_req       in   1      access request, sampled only in IDLE
//   cpu_write     in   1      1 = write, 0 = read; latched with cpu_req
//   cpu_address   in   [15:31] word address; latched with cpu_req
//   cpu_wdata     in   [0:31] write data; latched with cpu_req
//   cpu_rdata     out  [0:31] read data, registered, valid when cpu_ack=1
//   cpu_ack       out  1      one-cycle completion pulse
//   cpu_busy      out  1      1 whenever state != IDLE
//   bus_error     out  1      one-cycle pulse with cpu_ack on out-of-range access
//   mem_address   out  [15:31] RAM word address
//   mem_write_en  out  1      RAM write strobe (RAM writes on rising edge)
//   mem_wdata     out  [0:31] RAM write data
//   mem_rdata     in   [0:31] RAM combinational read data
//   sim_end       out  1      sticky halt indication
// BEHAVIOUR
//   Reset (async, low): state=IDLE; cpu_rdata, mem_address, mem_wdata, latches = 0;
//     cpu_ack, bus_error, mem_write_en, sim_end = 0. Reset mid-access aborts it;
//     mem_write_en drops immediately; no partial write.
//   FSM IDLE -> WAIT -> COMPLETE -> ACK -> IDLE:
//   - IDLE: on cpu_req=1 latch write/address/wdata; go WAIT with count=WAIT_STATES,
//     or COMPLETE directly if WAIT_STATES=0.
//   - WAIT: count decrements each cycle; leave for COMPLETE after WAIT_STATES cycles.
//   - COMPLETE (1 cycle): write in range -> mem_write_en=1 (combinational from state);
//     read -> cpu_rdata <= mem_rdata at cycle end; out of range -> no write, cpu_rdata <= 0.
//   - ACK (1 cycle): cpu_ack=1; bus_error=1 if out of range; next state IDLE.
//   Latency: cpu_ack high WAIT_STATES+2 edges after the edge sampling cpu_req.
//   Back-to-back spacing: WAIT_STATES+3 cycles.
//   cpu_req ignored outside IDLE. Still high in the first IDLE cycle after ACK = new request.
//   mem_address/mem_wdata always driven from latches, stable the whole access; held in IDLE.
//   Out of range: (cpu_address & ~ADDRESS_MASK) != 0; no masking/wrap to RAM.
//   sim_end: set at the COMPLETE edge of an in-range write with address==HALT_ADDRESS
//     and data==HALT_DATA; stays 1 until reset. Other writes to HALT_ADDRESS behave normally.
//   Bit numbering big-endian throughout: bit 0 = MSB.
// STRUCTURE
//   Shared header (`include'd): state encodings, WORD_W=32, ADDR_W=17 (bits [15:31]).
//   One sub-module: wait_state_counter. Loads WAIT_STATES on start; asserts done on its last cycle.
//   Everything else, FSM and latches, lives in memory_sequencer.
// TESTING
//   1 Read, WAIT_STATES=2, RAM[5]=32'hDEADBEEF, req addr 5 -> ack 4 edges later,
//     cpu_rdata=DEADBEEF, bus_error=0.
//   2 Write 32'h12345678 to addr 9 -> mem_write_en high exactly 1 cycle;
//     RAM[9]=12345678; read-back matches.
//   3 Write 32'h00010001 to 17'h00100 -> sim_end=1 after COMPLETE and sticky;
//     write 32'h00010002 to 17'h00100 instead -> sim_end stays 0.
//   4 Read/write addr 17'h00200 -> bus_error+ack pulse; cpu_rdata=0; mem_write_en never high.
//   5 reset low during WAIT of a write -> IDLE immediately; no RAM write; all outputs 0;
//     WAIT_STATES=0 build: ack 2 edges after req.
//   6 cpu_req held high through ACK -> second access starts in next IDLE cycle;
//     spacing exactly WAIT_STATES+3 cycles.

Source files
------------

// File: rtl/memory_sequencer_pkg.sv
// Shared types and widths for the CPU-to-RAM memory sequencer.
// Bit numbering is big-endian: bit 0 is the MSB of every bus.
package memory_sequencer_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_COMPLETE = 2'd2,
    ST_ACK      = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic              write;
    logic [0:ADDR_W-1] address;
    logic [0:WORD_W-1] wdata;
  } access_t;

  // Any address bit outside the implemented mask puts the access out of range.
  function automatic logic out_of_range(input logic [0:ADDR_W-1] address,
                                        input logic [0:ADDR_W-1] mask);
    return (address & ~mask) != '0;
  endfunction

endpackage

// File: rtl/memory_sequencer_wait_state_counter.sv
// Down-counter timing the WAIT phase of a sequencer access.
// Loads WAIT_STATES on start; done_c is high during the last wait cycle.
module wait_state_counter #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic done_c
);

  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (start) begin
      count <= CNT_W'(WAIT_STATES);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done_c = (count == CNT_W'(1));

endmodule

// File: rtl/memory_sequencer.sv
// Sequencer between the CPU memory port and the RAM: req/ack handshake,
// programmable wait states, out-of-range rejection and sticky halt detection.
module memory_sequencer
  import memory_sequencer_pkg::*;
#(
  parameter int unsigned   WAIT_STATES  = 2,
  parameter logic [15:31]  ADDRESS_MASK = 17'h1ff,
  parameter logic [15:31]  HALT_ADDRESS = 17'h00100,
  parameter logic [0:31]   HALT_DATA    = 32'h00010001
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_write,
  input  logic [15:31] cpu_address,
  input  logic [0:31]  cpu_wdata,
  output logic [0:31]  cpu_rdata,
  output logic         cpu_ack,
  output logic         cpu_busy,
  output logic         bus_error,
  output logic [15:31] mem_address,
  output logic         mem_write_en,
  output logic [0:31]  mem_wdata,
  input  logic [0:31]  mem_rdata,
  output logic         sim_end
);

  seq_state_e state;
  seq_state_e next_state;
  access_t    acc_q;
  logic       wait_start_c;
  logic       wait_done_c;
  logic       accept_c;
  logic       oor_c;
  logic       halt_hit_c;

  wait_state_counter #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_state_counter (
    .clock  (clock),
    .reset  (reset),
    .start  (wait_start_c),
    .done_c (wait_done_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; the write strobe is decoded straight from state so reset kills it at once.
  always_comb begin
    next_state   = state;
    wait_start_c = 1'b0;
    accept_c     = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_req) begin
          accept_c = 1'b1;
          if (WAIT_STATES == 0) begin
            next_state = ST_COMPLETE;
          end else begin
            next_state   = ST_WAIT;
            wait_start_c = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_done_c) next_state = ST_COMPLETE;
      end
      ST_COMPLETE: begin
        mem_write_en = acc_q.write && !oor_c;
        next_state   = ST_ACK;
      end
      ST_ACK: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign oor_c      = out_of_range(acc_q.address, ADDRESS_MASK);
  assign halt_hit_c = acc_q.write && !oor_c &&
                      (acc_q.address == HALT_ADDRESS) && (acc_q.wdata == HALT_DATA);

  // Request latches, read capture and registered completion flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      bus_error <= 1'b0;
      sim_end   <= 1'b0;
    end else begin
      cpu_ack   <= (state == ST_ACK);
      bus_error <= (state == ST_ACK) && oor_c;
      if (accept_c) begin
        acc_q <= {cpu_write, cpu_address, cpu_wdata};
      end
      if (state == ST_COMPLETE) begin
        if (oor_c) begin
          cpu_rdata <= '0;
        end else if (!acc_q.write) begin
          cpu_rdata <= mem_rdata;
        end
        if (halt_hit_c) begin
          sim_end <= 1'b1;
        end
      end
    end
  end

  assign cpu_busy    = (state != ST_IDLE);
  assign mem_address = acc_q.address;
  assign mem_wdata   = acc_q.wdata;

endmodule

// File: tb/tb_memory_sequencer.sv
// Directed bench for memory_sequencer: a 2-wait-state build and a 0-wait-state build,
// each driving its own behavioural RAM.
module tb_memory_sequencer;

  logic        clock;
  logic        reset;

  logic        cpu_req, cpu_write;
  logic [16:0] cpu_address;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_busy, bus_error;
  logic [16:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_wdata, mem_rdata;
  logic        sim_end;

  logic        cpu_req0, cpu_write0;
  logic [16:0] cpu_address0;
  logic [31:0] cpu_wdata0, cpu_rdata0;
  logic        cpu_ack0, cpu_busy0, bus_error0;
  logic [16:0] mem_address0;
  logic        mem_write_en0;
  logic [31:0] mem_wdata0, mem_rdata0;
  logic        sim_end0;

  logic [31:0] ram  [0:511];
  logic [31:0] ram0 [0:511];
  logic        bd_we;
  logic [8:0]  bd_addr;
  logic [31:0] bd_data;
  int          we_cnt = 0;

  int n_checks = 0;
  int n_fail   = 0;

  memory_sequencer #(.WAIT_STATES(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_write    (cpu_write),
    .cpu_address  (cpu_address),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .cpu_busy     (cpu_busy),
    .bus_error    (bus_error),
    .mem_address  (mem_address),
    .mem_write_en (mem_write_en),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .sim_end      (sim_end)
  );

  memory_sequencer #(.WAIT_STATES(0)) dut0 (
    .clock        (clock),
    .reset        (reset),
    .cpu_req      (cpu_req0),
    .cpu_write    (cpu_write0),
    .cpu_address  (cpu_address0),
    .cpu_wdata    (cpu_wdata0),
    .cpu_rdata    (cpu_rdata0),
    .cpu_ack      (cpu_ack0),
    .cpu_busy     (cpu_busy0),
    .bus_error    (bus_error0),
    .mem_address  (mem_address0),
    .mem_write_en (mem_write_en0),
    .mem_wdata    (mem_wdata0),
    .mem_rdata    (mem_rdata0),
    .sim_end      (sim_end0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM models: synchronous write, combinational read, backdoor preload on the first one.
  always @(posedge clock) begin
    if (mem_write_en && mem_address[16:9] == 8'd0) ram[mem_address[8:0]] <= mem_wdata;
    else if (bd_we) ram[bd_addr] <= bd_data;
    if (mem_write_en) we_cnt <= we_cnt + 1;
    if (mem_write_en0 && mem_address0[16:9] == 8'd0) ram0[mem_address0[8:0]] <= mem_wdata0;
  end
  assign mem_rdata  = (mem_address[16:9] == 8'd0)  ? ram[mem_address[8:0]]   : 32'hBAD0BAD0;
  assign mem_rdata0 = (mem_address0[16:9] == 8'd0) ? ram0[mem_address0[8:0]] : 32'hBAD0BAD0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bd_write(input logic [8:0] a, input logic [31:0] d);
    @(negedge clock);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clock);
    bd_we = 1'b0;
  endtask

  task automatic access(input logic wr, input logic [16:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int lat);
    @(negedge clock);
    cpu_req = 1'b1; cpu_write = wr; cpu_address = a; cpu_wdata = d;
    @(posedge clock);
    #1 cpu_req = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (cpu_ack) begin
        lat = i;
        break;
      end
    end
    rd  = cpu_rdata;
    err = bus_error;
  endtask

  task automatic access0(input logic wr, input logic [16:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
    @(negedge clock);
    cpu_req0 = 1'b1; cpu_write0 = wr; cpu_address0 = a; cpu_wdata0 = d;
    @(posedge clock);
    #1 cpu_req0 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (cpu_ack0) begin
        lat = i;
        break;
      end
    end
    rd = cpu_rdata0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          we0;
    int          ack_t [0:1];
    int          n_ack;

    cpu_req = 0; cpu_write = 0; cpu_address = '0; cpu_wdata = '0;
    cpu_req0 = 0; cpu_write0 = 0; cpu_address0 = '0; cpu_wdata0 = '0;
    bd_we = 0; bd_addr = '0; bd_data = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_ack",   32'(cpu_ack), 32'd0);
    check("rst_busy",  32'(cpu_busy), 32'd0);
    check("rst_simend", 32'(sim_end), 32'd0);
    check("rst_maddr", 32'(mem_address), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;

    bd_write(9'd5, 32'hDEADBEEF);
    bd_write(9'd0, 32'h0BADF00D);
    bd_write(9'd20, 32'h00000000);
    bd_write(9'd9, 32'h00000000);

    // Plain read with two wait states
    access(1'b0, 17'd5, 32'd0, rd, err, lat);
    check("t1_lat", 32'(lat), 32'd4);
    check("t1_rdata", rd, 32'hDEADBEEF);
    check("t1_err", 32'(err), 32'd0);

    // Write then read back
    we0 = we_cnt;
    access(1'b1, 17'd9, 32'h12345678, rd, err, lat);
    check("t2_lat", 32'(lat), 32'd4);
    check("t2_we_cycles", 32'(we_cnt - we0), 32'd1);
    check("t2_ram", ram[9], 32'h12345678);
    access(1'b0, 17'd9, 32'd0, rd, err, lat);
    check("t2_readback", rd, 32'h12345678);

    // Halt address: wrong data is a normal write, right data sets sticky sim_end
    access(1'b1, 17'h00100, 32'h00010002, rd, err, lat);
    check("t3_no_halt", 32'(sim_end), 32'd0);
    check("t3_ram_halt", ram[256], 32'h00010002);
    access(1'b1, 17'h00100, 32'h00010001, rd, err, lat);
    check("t3_halt", 32'(sim_end), 32'd1);
    access(1'b0, 17'd5, 32'd0, rd, err, lat);
    check("t3_sticky", 32'(sim_end), 32'd1);

    // Out-of-range accesses
    access(1'b0, 17'h00200, 32'd0, rd, err, lat);
    check("t4_rd_err", 32'(err), 32'd1);
    check("t4_rd_data", rd, 32'd0);
    check("t4_rd_lat", 32'(lat), 32'd4);
    @(posedge clock); #1;
    check("t4_ack_pulse", 32'(cpu_ack), 32'd0);
    check("t4_err_pulse", 32'(bus_error), 32'd0);
    we0 = we_cnt;
    access(1'b1, 17'h00200, 32'hFFFFFFFF, rd, err, lat);
    check("t4_wr_err", 32'(err), 32'd1);
    check("t4_wr_we", 32'(we_cnt - we0), 32'd0);
    check("t4_no_wrap", ram[0], 32'h0BADF00D);

    // Reset in the middle of a write's WAIT phase
    we0 = we_cnt;
    @(negedge clock);
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_address = 17'd20; cpu_wdata = 32'hCAFEF00D;
    @(posedge clock);
    #1 cpu_req = 1'b0;
    @(posedge clock);
    #1;
    check("t5_busy_wait", 32'(cpu_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_busy", 32'(cpu_busy), 32'd0);
    check("t5_we", 32'(mem_write_en), 32'd0);
    check("t5_maddr", 32'(mem_address), 32'd0);
    check("t5_mwdata", mem_wdata, 32'd0);
    check("t5_simend", 32'(sim_end), 32'd0);
    check("t5_rdata", cpu_rdata, 32'd0);
    @(negedge clock) reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("t5_no_write", 32'(we_cnt - we0), 32'd0);
    check("t5_ram", ram[20], 32'd0);

    // Zero-wait-state build
    access0(1'b1, 17'd3, 32'hA5A50001, rd, lat);
    check("t5b_wr_lat", 32'(lat), 32'd2);
    access0(1'b0, 17'd3, 32'd0, rd, lat);
    check("t5b_rd_lat", 32'(lat), 32'd2);
    check("t5b_rd_data", rd, 32'hA5A50001);
    check("t5b_err", 32'(bus_error0), 32'd0);
    check("t5b_simend", 32'(sim_end0), 32'd0);

    // cpu_req held high through ACK starts a second access straight away
    @(negedge clock);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 17'd5;
    @(posedge clock);
    n_ack = 0;
    ack_t[0] = 0; ack_t[1] = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clock);
      #1;
      if (cpu_ack) begin
        if (n_ack < 2) ack_t[n_ack] = i;
        n_ack++;
      end
      if (n_ack == 1 && i == ack_t[0] + 1) cpu_req = 1'b0;
    end
    cpu_req = 1'b0;
    check("t6_first_ack", 32'(ack_t[0]), 32'd4);
    check("t6_second_ack", 32'(ack_t[1]), 32'd9);
    check("t6_ack_count", 32'(n_ack), 32'd2);
    check("t6_rdata", cpu_rdata, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
